// File: rtl/fpu_issue_sched.sv
// FP issue/writeback scheduler: one op per cycle, per-class latency,
// latency reservation table guarantees a single writeback per cycle.
module fpu_issue_sched #(
  parameter int TAG_W         = 5,
  parameter int MAX_LAT       = 15,
  parameter int LAT_ADD       = 3,
  parameter int LAT_MUL       = 3,
  parameter int LAT_DIV       = 10,
  parameter int LAT_SQRT      = 7,
  parameter int LAT_CVT       = 1,
  parameter int LAT_MISC      = 1,
  parameter int DIV_PIPELINED = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [3:0]                     issue_op,
  input  logic [TAG_W-1:0]               issue_tag,
  input  logic                           flush,
  output logic [5:0]                     unit_start,
  output logic                           wb_valid,
  output logic [TAG_W-1:0]               wb_tag,
  output logic [3:0]                     wb_op,
  output logic [$clog2(MAX_LAT+1)-1:0]   inflight,
  output logic                           busy
);

  localparam int LW = $clog2(MAX_LAT + 1);

  if (LAT_ADD  < 1 || LAT_ADD  > MAX_LAT ||
      LAT_MUL  < 1 || LAT_MUL  > MAX_LAT ||
      LAT_DIV  < 1 || LAT_DIV  > MAX_LAT ||
      LAT_SQRT < 1 || LAT_SQRT > MAX_LAT ||
      LAT_CVT  < 1 || LAT_CVT  > MAX_LAT ||
      LAT_MISC < 1 || LAT_MISC > MAX_LAT) begin : g_bad_lat
    $error("fpu_issue_sched: LAT_* must lie in 1..MAX_LAT");
  end

  localparam logic [LW-1:0] L_ADD  = LW'(LAT_ADD);
  localparam logic [LW-1:0] L_MUL  = LW'(LAT_MUL);
  localparam logic [LW-1:0] L_DIV  = LW'(LAT_DIV);
  localparam logic [LW-1:0] L_SQRT = LW'(LAT_SQRT);
  localparam logic [LW-1:0] L_CVT  = LW'(LAT_CVT);
  localparam logic [LW-1:0] L_MISC = LW'(LAT_MISC);

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
  } slot_t;

  // Index k holds the op that completes k+1 edges from now.
  slot_t slot_q [MAX_LAT];
  slot_t slot_d [MAX_LAT];
  slot_t shift_s [MAX_LAT];

  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [3:0]       wb_op_q, wb_op_d;
  logic [LW-1:0]    inflight_q, inflight_d;
  logic             div_busy_q, div_busy_d;
  logic             sqrt_busy_q, sqrt_busy_d;

  logic [5:0]    cls;
  logic [LW-1:0] lat;
  logic [LW-1:0] idx;
  logic          collide;
  logic          blocked;
  logic          accept;

  always_comb begin
    cls = 6'b100000;
    lat = L_MISC;
    unique case (issue_op)
      4'd0, 4'd1: begin
        cls = 6'b000001;
        lat = L_ADD;
      end
      4'd2: begin
        cls = 6'b000010;
        lat = L_MUL;
      end
      4'd3: begin
        cls = 6'b000100;
        lat = L_DIV;
      end
      4'd4: begin
        cls = 6'b001000;
        lat = L_SQRT;
      end
      4'd11, 4'd12: begin
        cls = 6'b010000;
        lat = L_CVT;
      end
      default: begin
        cls = 6'b100000;
        lat = L_MISC;
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      shift_s[k] = slot_q[k+1];
    end
    shift_s[MAX_LAT-1] = '0;
  end

  always_comb begin
    idx     = lat - LW'(1);
    collide = shift_s[idx].v;
    blocked = (DIV_PIPELINED == 0) &&
              ((cls[2] && div_busy_q) ||
               (cls[3] && sqrt_busy_q));
    issue_ready = !rst && !flush && !collide && !blocked;
    accept      = issue_valid && issue_ready;
    unit_start  = accept ? cls : 6'b0;
  end

  always_comb begin
    slot_d = shift_s;
    if (accept) begin
      slot_d[idx] = '{v: 1'b1, tag: issue_tag, op: issue_op};
    end
    if (flush) begin
      slot_d = '{default: '0};
    end
  end

  always_comb begin
    wb_valid_d = slot_d[0].v;
    wb_tag_d   = slot_d[0].v ? slot_d[0].tag : wb_tag_q;
    wb_op_d    = slot_d[0].v ? slot_d[0].op : wb_op_q;
  end

  always_comb begin
    inflight_d = inflight_q + LW'(accept) - LW'(wb_valid_q);
    if (flush) begin
      inflight_d = '0;
    end
  end

  // A blocking unit frees up on the edge its result enters writeback.
  always_comb begin
    div_busy_d  = div_busy_q;
    sqrt_busy_d = sqrt_busy_q;
    if (accept && cls[2]) begin
      div_busy_d = 1'b1;
    end
    if (accept && cls[3]) begin
      sqrt_busy_d = 1'b1;
    end
    if (slot_d[0].v && slot_d[0].op == 4'd3) begin
      div_busy_d = 1'b0;
    end
    if (slot_d[0].v && slot_d[0].op == 4'd4) begin
      sqrt_busy_d = 1'b0;
    end
    if (flush) begin
      div_busy_d  = 1'b0;
      sqrt_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '{default: '0};
      wb_valid_q  <= 1'b0;
      wb_tag_q    <= '0;
      wb_op_q     <= '0;
      inflight_q  <= '0;
      div_busy_q  <= 1'b0;
      sqrt_busy_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      wb_valid_q  <= wb_valid_d;
      wb_tag_q    <= wb_tag_d;
      wb_op_q     <= wb_op_d;
      inflight_q  <= inflight_d;
      div_busy_q  <= div_busy_d;
      sqrt_busy_q <= sqrt_busy_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_tag   = wb_tag_q;
  assign wb_op    = wb_op_q;
  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
- Issue/writeback scheduler for the FP datapath. Accepts one FP op per cycle with a tag and pulses the start strobe of the selected unit class.
- Tracks every in-flight op in a latency reservation table and emits exactly one writeback per op, in the cycle its unit result is valid.
- Supersedes the single-op state counter. Allows overlapped issue of ops with different latencies.
- Has parametrised per-class latencies, an optional non-pipelined divider/sqrt mode, and flush.

Parameters:
- TAG_W, 5, width of the op tag carried to writeback
- MAX_LAT, 15, deepest latency supported; sizes the reservation table
- LAT_ADD, 3, latency of fadd/fsub (op 0,1)
- LAT_MUL, 3, latency of fmul (op 2)
- LAT_DIV, 10, latency of fdiv (op 3)
- LAT_SQRT, 7, latency of fsqrt (op 4)
- LAT_CVT, 1, latency of fcvt.w.s/fcvt.s.w (op 11,12)
- LAT_MISC, 1, latency of sgnj/sgnjn/sgnjx/feq/fle/flt and undefined codes (op 5-10,13-15)
- DIV_PIPELINED, 1, 1: div/sqrt accept a new op every cycle; 0: each of div and sqrt is blocking

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  op offered
- issue_ready  out  1  op accepted when issue_valid&&issue_ready at rising edge
- issue_op  in  4  fpuop code (same encoding as fpu)
- issue_tag  in  TAG_W  tag returned at writeback
- flush  in  1  synchronous cancel of all in-flight ops
- unit_start  out  6  one-hot start {misc,cvt,sqrt,div,mul,add}; high in acceptance cycle only
- wb_valid  out  1  writeback pulse
- wb_tag  out  TAG_W  tag of completing op
- wb_op  out  4  op code of completing op (drives result mux)
- inflight  out  $clog2(MAX_LAT+1)  ops accepted and not yet written back
- busy  out  1  inflight!=0

Behaviour:
- Elaboration error if any LAT_* is outside 1..MAX_LAT.
- Class latency L(op) is selected from issue_op. Undefined codes use the misc class.
- Reservation table: slot[1..MAX_LAT], each holding {valid, tag, op}. Every cycle slot[k] <= slot[k+1], and slot[MAX_LAT] is cleared.
- On acceptance at edge t, the entry is written into slot[L] (post-shift position). Registered wb_* is loaded from slot[1].
- Result: wb_valid is high for exactly the one cycle following edge t+L-1, i.e. L cycles after the acceptance edge. L=1 means the cycle right after acceptance.
- issue_ready is combinational. It is low when any of the following holds:
  - rst or flush is high;
  - the slot that will hold the new op is already valid after shift (writeback collision);
  - DIV_PIPELINED=0 and the op is div (or sqrt) while a div (resp. sqrt) is in flight.
- Otherwise issue_ready is high. issue_ready may depend on issue_op. The upstream holds op/tag stable while valid && !ready.
- unit_start = one-hot class of issue_op, gated by issue_valid&&issue_ready. It is combinational and shares the acceptance cycle with operands.
- In-order writeback is not guaranteed: a misc op issued after a div completes first. Tags disambiguate.
- inflight: +1 on accept, -1 when wb_valid is high. Simultaneous accept and wb leaves it unchanged. It never exceeds MAX_LAT.
- Flush: at the edge where flush=1, all slots, wb_valid, the non-pipelined busy flags and inflight clear to 0. No op is accepted in that cycle. A wb_valid already high in the flush cycle is still delivered (it was registered earlier).
- Reset: rst=1 at an edge gives the same state as flush. This applies mid-operation as well. The reset value of every output is:
  - issue_ready=0 while rst=1;
  - unit_start=0;
  - wb_valid=0, wb_tag=0, wb_op=0;
  - inflight=0, busy=0.
- wb_tag and wb_op hold their last value when wb_valid=0.

Test Plan:
- Back-to-back adds: tags 1,2,3 on consecutive cycles, LAT_ADD=3 → wb_valid on cycles 3,4,5 after first accept with tags 1,2,3; inflight peaks at 3; unit_start[0] pulses three times.
- Collision: accept fadd (tag 4) at cycle 0, then offer feq at cycle 2 → issue_ready=0 at cycle 2 (both would complete at 3). feq is accepted at cycle 3 with wb at 4, and fadd wb (tag 4) at 3.
- Out-of-order: fdiv tag 7 at 0, fsgnj tag 8 at 1 → wb tag 8 at cycle 2, wb tag 7 at cycle 10.
- DIV_PIPELINED=0: fdiv at 0, fdiv offered at 1..10 → ready=0 until the cycle of the first div's wb, then accepted. fmul offered meanwhile is accepted.
- Flush: three ops in flight, flush pulse at cycle 2 → no further wb_valid, inflight=0 next cycle, ready=0 during flush, and a new op is accepted the cycle after.
- Reset mid-op: rst during fsqrt → all outputs 0 after the edge. With rst=1, issue_valid=1 is never accepted (unit_start stays 0).
